// File: rtl/dds_ctrl_if.sv
// Host-side bundle for dds_ctrl: table-load stream, sweep controls, and the
// RAM/frequency/amplitude drive towards the DDS core.
interface dds_ctrl_if #(
  parameter int WIDTH   = 10,
  parameter int MAX_AMP = 8,
  parameter int DWELL_W = 16
);
  localparam int FW = WIDTH / 2;

  logic               load_start;
  logic               load_valid;
  logic [MAX_AMP-1:0] load_data;
  logic               load_ready;
  logic               sweep_start;
  logic [FW-1:0]      f_start;
  logic [FW-1:0]      f_step;
  logic [FW-1:0]      f_stop;
  logic [DWELL_W-1:0] dwell;
  logic               abort;
  logic [MAX_AMP-1:0] amp_in;
  logic               busy;
  logic               done;
  logic               ram_wr;
  logic [WIDTH-1:0]   ram_addr;
  logic [MAX_AMP-1:0] ram_data;
  logic [FW-1:0]      freq_cntrl;
  logic [MAX_AMP-1:0] amp_out;

  modport master (
    output load_start, load_valid, load_data, sweep_start,
           f_start, f_step, f_stop, dwell, abort, amp_in,
    input  load_ready, busy, done, ram_wr, ram_addr, ram_data,
           freq_cntrl, amp_out
  );

  modport slave (
    input  load_start, load_valid, load_data, sweep_start,
           f_start, f_step, f_stop, dwell, abort, amp_in,
    output load_ready, busy, done, ram_wr, ram_addr, ram_data,
           freq_cntrl, amp_out
  );
endinterface

// File: rtl/dds_ctrl.sv
// DDS sequencer: streams a full waveform table into the DDS RAM and runs
// upward linear frequency sweeps with a per-step dwell.
module dds_ctrl #(
  parameter int WIDTH   = 10,
  parameter int MAX_AMP = 8,
  parameter int DWELL_W = 16
) (
  input  logic     clk,
  input  logic     res,
  dds_ctrl_if.slave bus
);
  localparam int FW = WIDTH / 2;
  localparam logic [WIDTH-1:0]   W_ONE  = 1;
  localparam logic [DWELL_W-1:0] DW_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [FW-1:0]      freq_q, freq_d;
  logic [FW-1:0]      step_q, step_d;
  logic [FW-1:0]      stop_q, stop_d;
  logic               term_q, term_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               ram_wr_q, ram_wr_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [MAX_AMP-1:0] data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [MAX_AMP-1:0] amp_q, amp_d;

  logic               accept;
  logic [FW:0]        next_f;
  logic [DWELL_W-1:0] dwell_eff;
  logic               clamp;

  assign accept    = (state_q == LOAD) && bus.load_valid;
  assign next_f    = {1'b0, freq_q} + {1'b0, step_q};
  assign dwell_eff = (bus.dwell == '0) ? DW_ONE : bus.dwell;
  // The extra bit of next_f catches wrap past the top of the frequency word.
  assign clamp     = (step_q == '0) || next_f[FW] || (next_f >= {1'b0, stop_q});

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    freq_d   = freq_q;
    step_d   = step_q;
    stop_d   = stop_q;
    term_d   = term_q;
    dwell_d  = dwell_q;
    dcnt_d   = dcnt_q;
    ram_wr_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end else if (bus.sweep_start) begin
          state_d = SWEEP;
          freq_d  = bus.f_start;
          step_d  = bus.f_step;
          stop_d  = bus.f_stop;
          dwell_d = dwell_eff;
          dcnt_d  = dwell_eff;
          term_d  = (bus.f_start >= bus.f_stop);
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (accept) begin
          ram_wr_d = 1'b1;
          addr_d   = wcnt_q;
          data_d   = bus.load_data;
          wcnt_d   = wcnt_q + W_ONE;
          if (wcnt_q == '1) state_d = DONE;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (dcnt_q <= DW_ONE) begin
          if (term_q) begin
            state_d = DONE;
          end else begin
            dcnt_d = dwell_q;
            if (clamp) begin
              freq_d = stop_q;
              term_d = 1'b1;
            end else begin
              freq_d = next_f[FW-1:0];
            end
          end
        end else begin
          dcnt_d = dcnt_q - DW_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == SWEEP);
    done_d = (state_d == DONE);
    // Mute while the table is being rewritten.
    amp_d  = (state_d == LOAD) ? '0 : bus.amp_in;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      freq_q   <= '0;
      step_q   <= '0;
      stop_q   <= '0;
      term_q   <= 1'b0;
      dwell_q  <= '0;
      dcnt_q   <= '0;
      ram_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      amp_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      freq_q   <= freq_d;
      step_q   <= step_d;
      stop_q   <= stop_d;
      term_q   <= term_d;
      dwell_q  <= dwell_d;
      dcnt_q   <= dcnt_d;
      ram_wr_q <= ram_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      amp_q    <= amp_d;
    end
  end

  assign bus.load_ready = (state_q == LOAD);
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ram_wr     = ram_wr_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign bus.freq_cntrl = freq_q;
  assign bus.amp_out    = amp_q;
endmodule

// File: tb/tb_dds_ctrl.sv
// Directed + randomized bench for dds_ctrl; sweeps are checked against a
// precomputed frequency list, loads against an expected write stream.
module tb_dds_ctrl;
  localparam int W  = 10;
  localparam int A  = 8;
  localparam int D  = 16;
  localparam int FW = W / 2;

  logic clk = 1'b0;
  logic res;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_amp = 1'b0;
  logic [A-1:0] amp_prev;

  always #5 clk = ~clk;

  dds_ctrl_if #(.WIDTH(W), .MAX_AMP(A), .DWELL_W(D)) bus ();
  dds_ctrl #(.WIDTH(W), .MAX_AMP(A), .DWELL_W(D)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    amp_prev = bus.amp_in;
    @(posedge clk);
    #1;
    if (rand_amp) bus.amp_in = A'($urandom);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_wr"},    bus.ram_wr, 0);
    chk({tag, "_addr"},  bus.ram_addr, 0);
    chk({tag, "_data"},  bus.ram_data, 0);
    chk({tag, "_freq"},  bus.freq_cntrl, 0);
    chk({tag, "_amp"},   bus.amp_out, 0);
    chk({tag, "_ready"}, bus.load_ready, 0);
  endtask

  // abort_at = ordinal of the accepted word that carries abort (0 = none)
  task automatic run_load(input bit rnd, input int abort_at);
    logic [A-1:0] d;
    bit v, ab, fin;
    int acc, writes;
    acc = 0; writes = 0; fin = 0; ab = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      chk("load_ready", bus.load_ready, 1);
      chk("load_busy", bus.busy, 1);
      v  = (cyc % 3) != 2;
      d  = rnd ? A'($urandom) : A'(acc);
      ab = v && (acc + 1 == abort_at);
      bus.load_valid = v;
      bus.load_data  = d;
      bus.abort      = ab;
      tick();
      bus.load_valid = 1'b0;
      bus.abort      = 1'b0;
      chk("load_wr", bus.ram_wr, v && !ab);
      if (v && !ab) begin
        chk("load_addr", bus.ram_addr, acc);
        chk("load_data", bus.ram_data, d);
        writes++;
      end
      chk("load_done", bus.done, (v && !ab && acc == 1023));
      if (ab) begin
        fin = 1;
      end else begin
        if (v) acc++;
        if (acc == 1024) fin = 1;
        else chk("load_amp_mute", bus.amp_out, 0);
      end
    end
    if (!fin) chk("load_timeout", 0, 1);
    if (abort_at != 0) begin
      chk("abort_busy", bus.busy, 0);
      chk("abort_ready", bus.load_ready, 0);
      tick();
      chk("abort_wr", bus.ram_wr, 0);
      chk("abort_done", bus.done, 0);
      chk("load_writes", writes, abort_at - 1);
    end else begin
      chk("ldone_busy", bus.busy, 0);
      chk("ldone_ready", bus.load_ready, 0);
      chk("ldone_amp", bus.amp_out, amp_prev);
      tick();
      chk("ldone_pulse", bus.done, 0);
      chk("ldone_busy2", bus.busy, 0);
      chk("ldone_wr", bus.ram_wr, 0);
      chk("load_writes", writes, 1024);
    end
  endtask

  // ev_kind: 0 none, 1 abort at step ev_k, 2 reset at ev_k, 3 start pulses at ev_k
  task automatic run_sweep(input int fs, input int fst, input int fsp, input int dw,
                           input int ev_k, input int ev_kind);
    int seq[$];
    int f, n, eff, total;
    bit term;
    f = fs;
    term = (fs >= fsp);
    seq.push_back(f);
    while (!term) begin
      n = f + fst;
      if (fst == 0 || n >= fsp || n > (1 << FW) - 1) begin
        f = fsp;
        term = 1;
      end else begin
        f = n;
      end
      seq.push_back(f);
    end
    eff   = (dw == 0) ? 1 : dw;
    total = seq.size() * eff;

    bus.f_start = FW'(fs);
    bus.f_step  = FW'(fst);
    bus.f_stop  = FW'(fsp);
    bus.dwell   = D'(dw);
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    bus.f_start = FW'($urandom);
    bus.f_step  = FW'($urandom);
    bus.f_stop  = FW'($urandom);
    bus.dwell   = D'($urandom_range(0, 9));

    for (int k = 0; k < total; k++) begin
      chk("sweep_freq", bus.freq_cntrl, seq[k / eff]);
      chk("sweep_busy", bus.busy, 1);
      chk("sweep_done", bus.done, 0);
      chk("sweep_wr", bus.ram_wr, 0);
      chk("sweep_ready", bus.load_ready, 0);
      chk("sweep_amp", bus.amp_out, amp_prev);
      if (k == ev_k && ev_kind == 1) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int h = 0; h < 3; h++) begin
          chk("sabort_freq", bus.freq_cntrl, seq[k / eff]);
          chk("sabort_busy", bus.busy, 0);
          chk("sabort_done", bus.done, 0);
          tick();
        end
        return;
      end
      if (k == ev_k && ev_kind == 2) begin
        res = 1'b1;
        tick();
        res = 1'b0;
        chk_idle_zero("sreset");
        tick();
        chk("sreset_freq2", bus.freq_cntrl, 0);
        chk("sreset_busy2", bus.busy, 0);
        return;
      end
      if (k == ev_k && ev_kind == 3) begin
        bus.sweep_start = 1'b1;
        bus.load_start  = 1'b1;
      end
      tick();
      bus.sweep_start = 1'b0;
      bus.load_start  = 1'b0;
    end
    chk("sweep_end_done", bus.done, 1);
    chk("sweep_end_busy", bus.busy, 0);
    chk("sweep_end_freq", bus.freq_cntrl, seq[$]);
    tick();
    chk("sweep_post_done", bus.done, 0);
    chk("sweep_post_busy", bus.busy, 0);
    chk("sweep_post_freq", bus.freq_cntrl, seq[$]);
  endtask

  initial begin
    logic [FW-1:0] fprev;
    res = 1'b1;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0;
    bus.sweep_start = 0; bus.f_start = 0; bus.f_step = 0; bus.f_stop = 0;
    bus.dwell = 0; bus.abort = 0; bus.amp_in = 0;
    repeat (2) tick();
    res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle_zero("reset_idle");
    end
    rand_amp = 1'b1;

    run_load(1'b0, 0);

    run_sweep(2, 3, 10, 4, -1, 0);
    run_sweep(28, 5, 31, 2, -1, 0);
    run_sweep(12, 4, 7, 2, -1, 0);
    run_sweep(5, 0, 20, 2, -1, 0);
    run_sweep(3, 4, 12, 0, -1, 0);
    for (int r = 0; r < 6; r++)
      run_sweep($urandom_range(0, 31), $urandom_range(0, 12),
                $urandom_range(0, 31), $urandom_range(0, 3), -1, 0);

    run_load(1'b1, 300);
    run_load(1'b1, 0);

    run_sweep(1, 2, 30, 3, 10, 1);

    // Simultaneous starts: load wins, sweep parameters must not take effect.
    fprev = bus.freq_cntrl;
    bus.f_start = fprev + 5'd3; bus.f_step = 5'd1; bus.f_stop = 5'd31; bus.dwell = 16'd2;
    bus.load_start = 1'b1; bus.sweep_start = 1'b1;
    tick();
    bus.load_start = 1'b0; bus.sweep_start = 1'b0;
    chk("both_ready", bus.load_ready, 1);
    chk("both_busy", bus.busy, 1);
    chk("both_freq", bus.freq_cntrl, fprev);
    chk("both_amp", bus.amp_out, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("both_abort_busy", bus.busy, 0);
    chk("both_abort_done", bus.done, 0);
    tick();
    chk("both_idle_freq", bus.freq_cntrl, fprev);
    chk("both_idle_ready", bus.load_ready, 0);

    run_sweep(0, 7, 31, 3, 5, 3);
    run_sweep(4, 3, 29, 2, 7, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dds_ctrl.md
Name: dds_ctrl

Overview:
- Sequencer for the DDS core. Owns the DDS RAM write port and frequency/amplitude controls.
- Two jobs: loads a full waveform table from a valid/ready word stream, and runs linear frequency sweeps (start, step, stop, dwell).
- Sits between the register/host interface and the DDS instance, one instance per DDS.

Parameters:
- WIDTH, 10, DDS phase/address width; table depth 2^WIDTH; frequency word WIDTH/2 bits.
- MAX_AMP, 8, sample and amplitude width.
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- res  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; begin table load.
- load_valid  in  1  load word valid.
- load_data  in  MAX_AMP  load word.
- load_ready  out  1  controller accepts a word this cycle.
- sweep_start  in  1  pulse; begin sweep using f_start/f_step/f_stop/dwell, sampled that cycle.
- f_start  in  WIDTH/2  first frequency word.
- f_step  in  WIDTH/2  increment per step.
- f_stop  in  WIDTH/2  final frequency word.
- dwell  in  DWELL_W  cycles per frequency step; 0 treated as 1.
- abort  in  1  terminate current operation.
- amp_in  in  MAX_AMP  requested amplitude.
- busy  out  1  high in LOAD or SWEEP.
- done  out  1  one-cycle pulse on normal completion.
- ram_wr  out  1  to DDS RAM_WR.
- ram_addr  out  WIDTH  to DDS RAM_address.
- ram_data  out  MAX_AMP  to DDS RAM_input.
- freq_cntrl  out  WIDTH/2  to DDS freq_cntrl.
- amp_out  out  MAX_AMP  to DDS AMP.

Behaviour:
- All outputs registered except load_ready, which is decoded from state.
- Reset values: state IDLE; busy, done, ram_wr = 0; ram_addr = 0; ram_data = 0; freq_cntrl = 0; amp_out = 0; load_ready = 0.
- States: IDLE, LOAD, SWEEP, DONE.

IDLE:
- load_start moves to LOAD next cycle.
- sweep_start latches the parameters and moves to SWEEP next cycle.
- If both are asserted in the same cycle, load_start wins and sweep_start is dropped.
- freq_cntrl holds its last value.

LOAD:
- load_ready = 1. Word counter starts at 0.
- Each cycle with load_valid & load_ready: next cycle ram_wr = 1, ram_addr = counter, ram_data = load_data; counter increments. One cycle latency from accept to write.
- Cycles without an accept: ram_wr = 0 next cycle.
- After word 2^WIDTH-1 is accepted: load_ready drops the following cycle, then go to DONE.
- amp_out is forced to 0 for the whole of LOAD (output muted while the table is inconsistent).

SWEEP:
- On entry, freq_cntrl = f_start and the dwell counter loads max(dwell,1).
- The counter decrements each cycle. At expiry:
  - If freq_cntrl was already at the terminal value, go to DONE.
  - Otherwise compute next = freq_cntrl + f_step in WIDTH/2+1 bits.
  - If next >= f_stop, or next overflows WIDTH/2 bits, or f_step == 0: freq_cntrl = f_stop and it becomes terminal.
  - Otherwise freq_cntrl = next. The counter reloads in both cases.
- If f_start >= f_stop, f_start is the terminal value: exactly one dwell, then DONE. No downward sweeps.
- ram_wr = 0 throughout SWEEP.

DONE:
- done = 1 for one cycle, then IDLE. freq_cntrl retains the final value.

abort:
- In LOAD or SWEEP: next cycle state = IDLE, ram_wr = 0, no done pulse, freq_cntrl holds its current value.
- Words already accepted have been written. A later load restarts at address 0.
- abort in IDLE or DONE is ignored. abort has priority over a simultaneous expiry or accept.

Start pulses while busy:
- load_start or sweep_start while busy is ignored; no queueing.

amp_out:
- Outside LOAD, amp_out is amp_in delayed one cycle.

Reset mid-operation:
- Reset wins over everything. All outputs return to reset values the next cycle, including freq_cntrl = 0.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy 0, load_ready 0.
- load_start, then 1024 words with data = addr[7:0], load_valid deasserted every 3rd cycle -> ram_wr pulses exactly 1024 times with ram_addr 0..1023 in order, each one cycle after its accept; no write on gap cycles; amp_out 0 during LOAD; single done pulse; busy 0 after.
- sweep_start with f_start=2, f_step=3, f_stop=10, dwell=4 -> freq_cntrl 2,5,8,10, each held 4 cycles; done pulses the cycle after the 16th; freq_cntrl stays 10.
- Overflow and degenerate cases, each with dwell=2:
  - f_start=28, f_step=5, f_stop=31 -> freq sequence 28, 31.
  - f_start=12, f_stop=7 -> 12 for 2 cycles, then done.
  - f_step=0 -> jumps from f_start to f_stop.
  - dwell=0 -> each step behaves as dwell=1.
- abort on the 300th accepted word of a load, then a new load -> ram_wr off the next cycle, no done, busy 0; the new load writes from address 0. abort mid-sweep -> freq_cntrl frozen at its current value.
- load_start and sweep_start in the same cycle -> LOAD entered and the sweep is dropped. sweep_start while busy -> ignored. res asserted mid-sweep -> freq_cntrl 0 the next cycle.
